// File: rtl/y86_pkg.sv
// Shared definitions for the Y86-64 SEQ sequencer: instruction codes,
// status codes, the sequencer state encoding and instruction-class helpers.
package y86_pkg;

    localparam logic [3:0] I_HALT   = 4'h0;
    localparam logic [3:0] I_NOP    = 4'h1;
    localparam logic [3:0] I_RRMOVQ = 4'h2;
    localparam logic [3:0] I_IRMOVQ = 4'h3;
    localparam logic [3:0] I_RMMOVQ = 4'h4;
    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_OPQ    = 4'h6;
    localparam logic [3:0] I_JXX    = 4'h7;
    localparam logic [3:0] I_CALL   = 4'h8;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_PUSHQ  = 4'hA;
    localparam logic [3:0] I_POPQ   = 4'hB;

    localparam logic [2:0] S_AOK = 3'd1;
    localparam logic [2:0] S_HLT = 3'd2;
    localparam logic [2:0] S_ADR = 3'd3;
    localparam logic [2:0] S_INS = 3'd4;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_FETCH,
        ST_DECODE,
        ST_EXECUTE,
        ST_MEMORY,
        ST_WB_E,
        ST_WB_M,
        ST_PCUPD,
        ST_HALTED
    } state_t;

    // Instructions that touch data memory (stores, loads, stack ops).
    function automatic logic uses_mem(input logic [3:0] icode);
        return icode inside {I_RMMOVQ, I_MRMOVQ, I_CALL, I_RET, I_PUSHQ, I_POPQ};
    endfunction

    // Instructions that write valE to dstE; a conditional move only writes
    // when its condition holds.
    function automatic logic writes_e(input logic [3:0] icode, input logic cnd);
        case (icode)
            I_RRMOVQ:                                      return cnd;
            I_IRMOVQ, I_OPQ, I_CALL, I_RET, I_PUSHQ, I_POPQ: return 1'b1;
            I_HALT, I_NOP, I_RMMOVQ, I_MRMOVQ, I_JXX:     return 1'b0;
            default:                                       return 1'b0;
        endcase
    endfunction

    // Instructions that write the loaded value valM to dstM.
    function automatic logic writes_m(input logic [3:0] icode);
        return icode inside {I_MRMOVQ, I_POPQ};
    endfunction

endpackage

// File: rtl/seq_stage_ctrl_if.sv
// Handshake and control bundle between the SEQ sequencer and the datapath.
// The master side is the sequencer; the slave side is fetch/execute/memory
// plus the register file and PC register.
interface seq_stage_ctrl_if #(
    parameter int CNT_W = 32
) ();

    // Datapath -> sequencer
    logic             start;
    logic [3:0]       icode;
    logic             instr_valid;
    logic             imem_ack;
    logic             imem_error;
    logic             cnd;
    logic             dmem_ack;
    logic             dmem_error;

    // Sequencer -> datapath
    logic             fetch_en;
    logic             decode_en;
    logic             exec_en;
    logic             dmem_req;
    logic             rf_we;
    logic             rf_wsel;
    logic             pc_we;
    logic [2:0]       stat;
    logic             busy;
    logic [CNT_W-1:0] cycle_cnt;
    logic [CNT_W-1:0] instr_cnt;

    modport master (
        input  start, icode, instr_valid, imem_ack, imem_error, cnd,
               dmem_ack, dmem_error,
        output fetch_en, decode_en, exec_en, dmem_req, rf_we, rf_wsel,
               pc_we, stat, busy, cycle_cnt, instr_cnt
    );

    modport slave (
        output start, icode, instr_valid, imem_ack, imem_error, cnd,
               dmem_ack, dmem_error,
        input  fetch_en, decode_en, exec_en, dmem_req, rf_we, rf_wsel,
               pc_we, stat, busy, cycle_cnt, instr_cnt
    );

endinterface

// File: rtl/seq_wait_timer.sv
// Wait-cycle timer for the MEMORY stage. Counts up from zero while enabled
// and flags the last permitted wait cycle (count == MEM_TIMEOUT-1).
module seq_wait_timer #(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clr,
    input  logic i_en,
    output logic o_expired
);

    localparam int TW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [TW-1:0] LAST = TW'(MEM_TIMEOUT - 1);

    logic [TW-1:0] r_cnt;

    // Count wait cycles, saturating at the terminal value until cleared.
    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_cnt <= '0;
        end else if (i_en && (r_cnt != LAST)) begin
            r_cnt <= r_cnt + TW'(1);
        end
    end

    assign o_expired = i_en && (r_cnt == LAST);

endmodule

// File: rtl/seq_stage_ctrl.sv
// Multi-cycle sequencer for the Y86-64 SEQ datapath. Walks each instruction
// through fetch, decode, execute, memory, writeback and PC update, drives the
// per-stage strobes, shares the single register-file write port between valE
// and valM, and owns the architectural status code.
module seq_stage_ctrl
    import y86_pkg::*;
#(
    parameter int CNT_W       = 32,
    parameter int MEM_TIMEOUT = 16
) (
    input  logic             clk,
    input  logic             rst,
    seq_stage_ctrl_if.master io_bus
);

    state_t           r_state;
    logic [2:0]       r_stat;
    logic [3:0]       r_icode;
    logic             r_fetch_en;
    logic             r_decode_en;
    logic             r_exec_en;
    logic             r_dmem_req;
    logic             r_rf_we;
    logic             r_rf_wsel;
    logic             r_pc_we;
    logic             r_busy;
    logic [CNT_W-1:0] r_cycle_cnt;
    logic [CNT_W-1:0] r_instr_cnt;

    state_t           w_next_state;
    logic [2:0]       w_next_stat;
    logic             w_tmr_clr;
    logic             w_tmr_en;
    logic             w_tmr_expired;

    // The timer runs only in MEMORY; any other state clears it so every
    // memory access starts counting from zero.
    assign w_tmr_en  = (r_state == ST_MEMORY);
    assign w_tmr_clr = (r_state != ST_MEMORY);

    seq_wait_timer #(
        .MEM_TIMEOUT (MEM_TIMEOUT)
    ) u_wait_timer (
        .clk       (clk),
        .rst       (rst),
        .i_clr     (w_tmr_clr),
        .i_en      (w_tmr_en),
        .o_expired (w_tmr_expired)
    );

    // Next-state and next-status selection from the current stage and the
    // datapath handshakes.
    always_comb begin
        w_next_state = r_state;
        w_next_stat  = r_stat;
        case (r_state)
            ST_IDLE: begin
                if (io_bus.start) begin
                    w_next_state = ST_FETCH;
                end
            end
            ST_FETCH: begin
                // A bad fetch address outranks an illegal or halt opcode.
                if (io_bus.imem_ack) begin
                    if (io_bus.imem_error) begin
                        w_next_state = ST_HALTED;
                        w_next_stat  = S_ADR;
                    end else if (!io_bus.instr_valid) begin
                        w_next_state = ST_HALTED;
                        w_next_stat  = S_INS;
                    end else if (io_bus.icode == I_HALT) begin
                        w_next_state = ST_HALTED;
                        w_next_stat  = S_HLT;
                    end else begin
                        w_next_state = ST_DECODE;
                    end
                end
            end
            ST_DECODE: begin
                w_next_state = ST_EXECUTE;
            end
            ST_EXECUTE: begin
                if (uses_mem(r_icode)) begin
                    w_next_state = ST_MEMORY;
                end else if (writes_e(r_icode, io_bus.cnd)) begin
                    w_next_state = ST_WB_E;
                end else begin
                    w_next_state = ST_PCUPD;
                end
            end
            ST_MEMORY: begin
                // An ack in the final wait cycle still completes the access.
                // cnd is irrelevant here: conditional moves never use memory.
                if (io_bus.dmem_ack) begin
                    if (io_bus.dmem_error) begin
                        w_next_state = ST_HALTED;
                        w_next_stat  = S_ADR;
                    end else if (writes_e(r_icode, 1'b0)) begin
                        w_next_state = ST_WB_E;
                    end else if (writes_m(r_icode)) begin
                        w_next_state = ST_WB_M;
                    end else begin
                        w_next_state = ST_PCUPD;
                    end
                end else if (w_tmr_expired) begin
                    w_next_state = ST_HALTED;
                    w_next_stat  = S_ADR;
                end
            end
            ST_WB_E: begin
                // popq writes the stack pointer first and the popped value
                // second, so popq %rsp ends with the popped value in rsp.
                if (writes_m(r_icode)) begin
                    w_next_state = ST_WB_M;
                end else begin
                    w_next_state = ST_PCUPD;
                end
            end
            ST_WB_M: begin
                w_next_state = ST_PCUPD;
            end
            ST_PCUPD: begin
                w_next_state = ST_FETCH;
            end
            ST_HALTED: begin
                w_next_state = ST_HALTED;
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // Sequencer state with Moore outputs registered from the next state, so
    // every strobe lines up exactly with the stage it belongs to.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_stat      <= S_AOK;
            r_fetch_en  <= 1'b0;
            r_decode_en <= 1'b0;
            r_exec_en   <= 1'b0;
            r_dmem_req  <= 1'b0;
            r_rf_we     <= 1'b0;
            r_rf_wsel   <= 1'b0;
            r_pc_we     <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_state     <= w_next_state;
            r_stat      <= w_next_stat;
            r_fetch_en  <= (w_next_state == ST_FETCH);
            r_decode_en <= (w_next_state == ST_DECODE);
            r_exec_en   <= (w_next_state == ST_EXECUTE);
            r_dmem_req  <= (w_next_state == ST_MEMORY);
            r_rf_we     <= (w_next_state == ST_WB_E) || (w_next_state == ST_WB_M);
            r_rf_wsel   <= (w_next_state == ST_WB_M);
            r_pc_we     <= (w_next_state == ST_PCUPD);
            r_busy      <= (w_next_state != ST_IDLE) && (w_next_state != ST_HALTED);
        end
    end

    // Capture the opcode when fetch delivers it; later stages decide on it.
    always_ff @(posedge clk) begin
        if ((r_state == ST_FETCH) && io_bus.imem_ack) begin
            r_icode <= io_bus.icode;
        end
    end

    // Performance counters: busy cycles and retired instructions, frozen in
    // IDLE and HALTED, wrapping silently.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cycle_cnt <= '0;
            r_instr_cnt <= '0;
        end else begin
            if (r_busy) begin
                r_cycle_cnt <= r_cycle_cnt + CNT_W'(1);
            end
            if (r_state == ST_PCUPD) begin
                r_instr_cnt <= r_instr_cnt + CNT_W'(1);
            end
        end
    end

    assign io_bus.fetch_en  = r_fetch_en;
    assign io_bus.decode_en = r_decode_en;
    assign io_bus.exec_en   = r_exec_en;
    assign io_bus.dmem_req  = r_dmem_req;
    assign io_bus.rf_we     = r_rf_we;
    assign io_bus.rf_wsel   = r_rf_wsel;
    assign io_bus.pc_we     = r_pc_we;
    assign io_bus.stat      = r_stat;
    assign io_bus.busy      = r_busy;
    assign io_bus.cycle_cnt = r_cycle_cnt;
    assign io_bus.instr_cnt = r_instr_cnt;

endmodule

// File: tb/tb_seq_stage_ctrl.sv
// Scoreboard bench for the SEQ sequencer. The driver plays fetch and data
// memory, predicts the observable events of every instruction (register
// writes, PC update, halt) from the instruction-class rules and queues them;
// a monitor pops and compares whenever the DUT strobes.
module tb_seq_stage_ctrl;

    localparam int CNT_W       = 32;
    localparam int MEM_TIMEOUT = 16;

    localparam int K_WE   = 0;
    localparam int K_PC   = 1;
    localparam int K_HALT = 2;

    typedef struct {
        int kind;
        int wsel;
        int cyc;
        int icnt;
        int stat;
    } ev_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    seq_stage_ctrl_if #(.CNT_W(CNT_W)) bus ();

    seq_stage_ctrl #(
        .CNT_W       (CNT_W),
        .MEM_TIMEOUT (MEM_TIMEOUT)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .io_bus (bus)
    );

    ev_t exq[$];
    int  n_checks = 0;
    int  n_pass   = 0;
    int  base_cyc = 0;
    int  retired  = 0;
    logic prev_busy = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    task automatic handle(input int kind);
        ev_t e;
        if (exq.size() == 0) begin
            chk("unexpected_event_kind", kind, -1);
            return;
        end
        e = exq.pop_front();
        chk("event_kind", kind, e.kind);
        if (kind != e.kind) return;
        case (kind)
            K_WE: chk("rf_wsel", int'(bus.rf_wsel), e.wsel);
            K_PC: begin
                chk("cycle_cnt_at_pcupd", int'(bus.cycle_cnt), e.cyc);
                chk("instr_cnt_at_pcupd", int'(bus.instr_cnt), e.icnt);
            end
            default: begin
                chk("halt_stat", int'(bus.stat), e.stat);
                chk("cycle_cnt_at_halt", int'(bus.cycle_cnt), e.cyc);
            end
        endcase
    endtask

    // Monitor: sample away from the active edge and match DUT events.
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.rf_we) handle(K_WE);
            if (bus.pc_we) handle(K_PC);
            if (prev_busy && !bus.busy && (bus.stat != 3'd1)) handle(K_HALT);
        end
        prev_busy <= bus.busy;
    end

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_fetch(output bit ok);
        int guard;
        guard = 0;
        while (!bus.fetch_en && guard < 100) begin
            next();
            guard++;
        end
        ok = bus.fetch_en;
        if (!ok) chk("fetch_en_within_budget", 0, 1);
    endtask

    task automatic do_reset(input bit expect_drained);
        if (expect_drained) chk("queue_drained_before_reset", exq.size(), 0);
        rst = 1'b1;
        bus.start = 1'b0;
        bus.imem_ack = 1'b0;
        bus.dmem_ack = 1'b0;
        next();
        next();
        exq.delete();
        base_cyc = 0;
        retired  = 0;
        rst = 1'b0;
        next();
    endtask

    task automatic do_start();
        bus.start = 1'b1;
        next();
        bus.start = 1'b0;
    endtask

    // Issue one instruction. Predicted events come from the instruction
    // classes: memory users, valE writers, valM writers.
    task automatic do_instr(input logic [3:0] ic, input bit valid, input bit ierr,
                            input bit c, input int iwait, input int dwait,
                            input bit derr, input bit tmo, output bit halted);
        bit   ok, mem, ffault;
        int   we_e, we_m, pre, guard;
        ev_t  e;
        halted = 1'b0;
        wait_fetch(ok);
        if (!ok) begin
            halted = 1'b1;
            return;
        end
        mem  = (ic == 4'h4) || (ic == 4'h5) || (ic == 4'h8) || (ic == 4'h9) ||
               (ic == 4'hA) || (ic == 4'hB);
        we_m = ((ic == 4'h5) || (ic == 4'hB)) ? 1 : 0;
        case (ic)
            4'h2:                                    we_e = c ? 1 : 0;
            4'h3, 4'h6, 4'h8, 4'h9, 4'hA, 4'hB:      we_e = 1;
            default:                                 we_e = 0;
        endcase
        ffault = ierr || !valid || (ic == 4'h0);
        if (ffault) begin
            halted = 1'b1;
            e = '{kind: K_HALT, wsel: 0, cyc: base_cyc + iwait + 1, icnt: retired,
                  stat: ierr ? 3 : (!valid ? 4 : 2)};
            exq.push_back(e);
        end else if (mem && (derr || tmo)) begin
            halted = 1'b1;
            e = '{kind: K_HALT, wsel: 0, icnt: retired, stat: 3,
                  cyc: base_cyc + iwait + 3 + (tmo ? MEM_TIMEOUT : dwait + 1)};
            exq.push_back(e);
        end else begin
            pre = base_cyc + iwait + 3 + (mem ? dwait + 1 : 0);
            if (we_e != 0) exq.push_back('{kind: K_WE, wsel: 0, cyc: 0, icnt: 0, stat: 0});
            if (we_m != 0) exq.push_back('{kind: K_WE, wsel: 1, cyc: 0, icnt: 0, stat: 0});
            exq.push_back('{kind: K_PC, wsel: 0, cyc: pre + we_e + we_m, icnt: retired, stat: 0});
            base_cyc = pre + we_e + we_m + 1;
            retired++;
        end
        bus.cnd = c;
        repeat (iwait) begin
            bus.imem_ack = 1'b0;
            next();
        end
        bus.imem_ack    = 1'b1;
        bus.icode       = ic;
        bus.instr_valid = valid;
        bus.imem_error  = ierr;
        next();
        bus.imem_ack    = 1'b0;
        bus.icode       = 4'($urandom);
        bus.instr_valid = 1'($urandom);
        bus.imem_error  = 1'($urandom);
        if (!ffault && mem) begin
            guard = 0;
            while (!bus.dmem_req && guard < 10) begin
                next();
                guard++;
            end
            if (!bus.dmem_req) begin
                chk("dmem_req_within_budget", 0, 1);
                return;
            end
            if (tmo) begin
                repeat (MEM_TIMEOUT + 1) next();
            end else begin
                repeat (dwait) begin
                    bus.dmem_ack = 1'b0;
                    next();
                end
                bus.dmem_ack   = 1'b1;
                bus.dmem_error = derr;
                next();
                bus.dmem_ack   = 1'b0;
                bus.dmem_error = 1'($urandom);
            end
        end
    endtask

    initial begin
        bit ok, h;
        int r, r2, iw, dw;
        logic [3:0] ic;
        bit vld, ie, de, tm;

        bus.start = 1'b0; bus.icode = 4'h0; bus.instr_valid = 1'b0;
        bus.imem_ack = 1'b0; bus.imem_error = 1'b0; bus.cnd = 1'b0;
        bus.dmem_ack = 1'b0; bus.dmem_error = 1'b0;

        // Reset state
        next();
        next();
        chk("rst_busy",      int'(bus.busy), 0);
        chk("rst_stat",      int'(bus.stat), 1);
        chk("rst_fetch_en",  int'(bus.fetch_en), 0);
        chk("rst_rf_we",     int'(bus.rf_we), 0);
        chk("rst_pc_we",     int'(bus.pc_we), 0);
        chk("rst_dmem_req",  int'(bus.dmem_req), 0);
        chk("rst_cycle_cnt", int'(bus.cycle_cnt), 0);
        chk("rst_instr_cnt", int'(bus.instr_cnt), 0);
        rst = 1'b0;
        next();
        next();
        chk("idle_without_start", int'(bus.busy), 0);

        // OPq with immediate acks
        do_start();
        do_instr(4'h6, 1'b1, 1'b0, 1'b0, 0, 0, 1'b0, 1'b0, h);
        wait_fetch(ok);
        chk("opq_instr_cnt", int'(bus.instr_cnt), 1);
        chk("opq_cycle_cnt", int'(bus.cycle_cnt), 5);

        // popq with a three-cycle memory wait
        do_instr(4'hB, 1'b1, 1'b0, 1'b1, 0, 2, 1'b0, 1'b0, h);
        // cmov with cnd=0: no register write
        do_instr(4'h2, 1'b1, 1'b0, 1'b0, 0, 0, 1'b0, 1'b0, h);
        wait_fetch(ok);

        // mrmovq with no memory ack: timeout
        do_instr(4'h5, 1'b1, 1'b0, 1'b0, 0, 0, 1'b0, 1'b1, h);
        repeat (3) next();
        chk("tmo_busy", int'(bus.busy), 0);
        chk("tmo_stat", int'(bus.stat), 3);
        do_reset(1'b1);
        do_start();

        // Fetch error outranks halt opcode; HALTED ignores start
        do_instr(4'h0, 1'b1, 1'b1, 1'b0, 0, 0, 1'b0, 1'b0, h);
        bus.start = 1'b1;
        repeat (3) next();
        bus.start = 1'b0;
        chk("halted_sticky_busy",  int'(bus.busy), 0);
        chk("halted_sticky_fetch", int'(bus.fetch_en), 0);
        chk("halted_sticky_stat",  int'(bus.stat), 3);
        chk("halted_cycle_frozen", int'(bus.cycle_cnt), 1);
        do_reset(1'b1);
        do_start();

        // Reset during WB_M of mrmovq
        do_instr(4'h5, 1'b1, 1'b0, 1'b0, 0, 0, 1'b0, 1'b0, h);
        chk("in_wb_m_wsel", int'(bus.rf_wsel), 1);
        rst = 1'b1;
        next();
        chk("midrst_busy",      int'(bus.busy), 0);
        chk("midrst_rf_we",     int'(bus.rf_we), 0);
        chk("midrst_pc_we",     int'(bus.pc_we), 0);
        chk("midrst_stat",      int'(bus.stat), 1);
        chk("midrst_cycle_cnt", int'(bus.cycle_cnt), 0);
        chk("midrst_instr_cnt", int'(bus.instr_cnt), 0);
        do_reset(1'b0);
        do_start();

        // Randomized instruction stream
        for (int n = 0; n < 150; n++) begin
            r   = $urandom_range(0, 99);
            r2  = $urandom_range(0, 99);
            ic  = 4'($urandom_range(1, 11));
            vld = 1'b1;
            ie  = 1'b0;
            if (r < 4) ic = 4'h0;
            else if (r < 7) vld = 1'b0;
            else if (r < 10) ie = 1'b1;
            de = (r2 < 5);
            tm = (r2 >= 5) && (r2 < 7);
            iw = $urandom_range(0, 2);
            dw = $urandom_range(0, 3);
            do_instr(ic, vld, ie, 1'($urandom), iw, dw, de, tm, h);
            if (h) begin
                repeat (3) next();
                do_reset(1'b1);
                do_start();
            end
        end
        wait_fetch(ok);
        repeat (2) next();
        chk("final_queue_drained", exq.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
